// File: rtl/scard_activation_seq_if.sv
// Host-side request/status bundle for the smartcard activation sequencer.
// The host drives activate/deactivate pulses and observes sequencer status.
interface scard_activation_seq_if;
    logic       activate_i;
    logic       deactivate_i;
    logic       ready_o;
    logic       atr_seen_o;
    logic       atr_timeout_o;
    logic [2:0] state_o;

    modport master (
        output activate_i,
        output deactivate_i,
        input  ready_o,
        input  atr_seen_o,
        input  atr_timeout_o,
        input  state_o
    );

    modport slave (
        input  activate_i,
        input  deactivate_i,
        output ready_o,
        output atr_seen_o,
        output atr_timeout_o,
        output state_o
    );
endinterface

// File: rtl/scard_activation_seq.sv
// ISO7816-3 contact activation/deactivation sequencer.
// Debounces card presence, sequences VCC -> clock -> RST release -> ATR wait,
// and runs the reverse deactivation sequence on removal, request or ATR timeout.
module scard_activation_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned T_PWR_CCLK      = 200,
    parameter int unsigned T_RST_CCLK      = 400,
    parameter int unsigned T_ATR_CCLK      = 40000,
    parameter int unsigned T_DEACT_CLK     = 16,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         reset_i,
    input  logic                         cclk_tick_i,
    input  logic                         card_inserted_i,
    input  logic                         scard_io_i,
    scard_activation_seq_if.slave        host,
    output logic                         card_power_en_o,
    output logic                         card_oe_o,
    output logic                         card_clk_en_o,
    output logic                         card_rst_o,
    output logic                         card_present_o
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [DEB_W-1:0]     DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] PWR_LAST   = CNT_WIDTH'(T_PWR_CCLK - 1);
    localparam logic [CNT_WIDTH-1:0] RST_LAST   = CNT_WIDTH'(T_RST_CCLK - 1);
    localparam logic [CNT_WIDTH-1:0] ATR_LAST   = CNT_WIDTH'(T_ATR_CCLK - 1);
    localparam logic [CNT_WIDTH-1:0] DEACT_LAST = CNT_WIDTH'(T_DEACT_CLK - 1);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_POWER_UP = 3'd1,
        S_CLK_ON   = 3'd2,
        S_WAIT_ATR = 3'd3,
        S_ACTIVE   = 3'd4,
        S_FAULT    = 3'd5,
        S_DEACT    = 3'd6
    } state_t;

    // Synchroniser stages
    logic ins_s1_q, ins_s2_q;
    logic io_s1_q, io_s2_q, io_s3_q;

    // Debounce
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             present_q, present_d;
    logic             present_fall;

    // Sequencer
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           step_q, step_d;
    logic                 pwr_q, pwr_d;
    logic                 oe_q, oe_d;
    logic                 clken_q, clken_d;
    logic                 rst_q, rst_d;
    logic                 ready_q, ready_d;
    logic                 seen_q, seen_d;
    logic                 timeout_q, timeout_d;
    logic                 io_fall;

    assign io_fall = io_s3_q & ~io_s2_q;

    // Presence debounce: toggle only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        deb_cnt_d = '0;
        present_d = present_q;
        if (ins_s2_q != present_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                present_d = ~present_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign present_fall = present_q & ~present_d;

    // Next-state, timing counter and registered pin/status values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        seen_d    = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            S_OFF: begin
                if (host.activate_i && present_q) begin
                    state_d   = S_POWER_UP;
                    timeout_d = 1'b0;
                end
            end
            S_POWER_UP: begin
                if (cclk_tick_i) begin
                    if (cnt_q == PWR_LAST) state_d = S_CLK_ON;
                    else                   cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_CLK_ON: begin
                if (cclk_tick_i) begin
                    if (cnt_q == RST_LAST) state_d = S_WAIT_ATR;
                    else                   cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_WAIT_ATR: begin
                // A start-bit edge beats a coincident final tick
                if (io_fall) begin
                    state_d = S_ACTIVE;
                    seen_d  = 1'b1;
                end else if (cclk_tick_i) begin
                    if (cnt_q == ATR_LAST) begin
                        state_d   = S_FAULT;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            S_ACTIVE: begin
                state_d = S_ACTIVE;
            end
            S_FAULT: begin
                state_d = S_DEACT;
            end
            S_DEACT: begin
                if (cnt_q == DEACT_LAST) begin
                    cnt_d  = '0;
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd2) state_d = S_OFF;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        // Removal outranks a host request; both override the per-state decision above
        if ((present_fall && (state_q inside {S_POWER_UP, S_CLK_ON, S_WAIT_ATR, S_ACTIVE, S_FAULT})) ||
            (host.deactivate_i && (state_q inside {S_POWER_UP, S_CLK_ON, S_WAIT_ATR, S_ACTIVE}))) begin
            state_d   = S_DEACT;
            seen_d    = 1'b0;
            timeout_d = timeout_q;
        end

        if (state_d != state_q) begin
            cnt_d  = '0;
            step_d = '0;
        end

        pwr_d   = 1'b0;
        oe_d    = 1'b0;
        clken_d = 1'b0;
        rst_d   = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            S_POWER_UP: begin
                pwr_d = 1'b1;
            end
            S_CLK_ON: begin
                pwr_d   = 1'b1;
                oe_d    = 1'b1;
                clken_d = 1'b1;
            end
            S_WAIT_ATR, S_ACTIVE: begin
                pwr_d   = 1'b1;
                oe_d    = 1'b1;
                clken_d = 1'b1;
                rst_d   = 1'b1;
                ready_d = (state_d == S_ACTIVE);
            end
            S_FAULT: begin
                pwr_d   = pwr_q;
                oe_d    = oe_q;
                clken_d = clken_q;
                rst_d   = rst_q;
            end
            S_DEACT: begin
                // Each step only ever drops a pin; pins already low stay low
                pwr_d   = pwr_q;
                oe_d    = oe_q & (step_d < 2'd2);
                clken_d = clken_q & (step_d == 2'd0);
            end
            default: begin
                pwr_d = 1'b0;
            end
        endcase
    end

    // Synchronisers and all sequencer state; io chain idles high
    always_ff @(posedge clk) begin
        if (reset_i) begin
            ins_s1_q  <= 1'b0;
            ins_s2_q  <= 1'b0;
            io_s1_q   <= 1'b1;
            io_s2_q   <= 1'b1;
            io_s3_q   <= 1'b1;
            deb_cnt_q <= '0;
            present_q <= 1'b0;
            state_q   <= S_OFF;
            cnt_q     <= '0;
            step_q    <= '0;
            pwr_q     <= 1'b0;
            oe_q      <= 1'b0;
            clken_q   <= 1'b0;
            rst_q     <= 1'b0;
            ready_q   <= 1'b0;
            seen_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ins_s1_q  <= card_inserted_i;
            ins_s2_q  <= ins_s1_q;
            io_s1_q   <= scard_io_i;
            io_s2_q   <= io_s1_q;
            io_s3_q   <= io_s2_q;
            deb_cnt_q <= deb_cnt_d;
            present_q <= present_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            pwr_q     <= pwr_d;
            oe_q      <= oe_d;
            clken_q   <= clken_d;
            rst_q     <= rst_d;
            ready_q   <= ready_d;
            seen_q    <= seen_d;
            timeout_q <= timeout_d;
        end
    end

    assign card_power_en_o    = pwr_q;
    assign card_oe_o          = oe_q;
    assign card_clk_en_o      = clken_q;
    assign card_rst_o         = rst_q;
    assign card_present_o     = present_q;
    assign host.ready_o       = ready_q;
    assign host.atr_seen_o    = seen_q;
    assign host.atr_timeout_o = timeout_q;
    assign host.state_o       = state_q;

endmodule

// File: tb/tb_scard_activation_seq.sv
// Directed bench for scard_activation_seq: vector table for reset/debounce/
// activation start, hand-written sequences for timing corners.
module tb_scard_activation_seq;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic cclk_tick = 1'b0;
    logic card_inserted = 1'b0;
    logic scard_io = 1'b1;
    logic pwr, oe, clken, crst, present;

    int unsigned total_cnt = 0;
    int unsigned pass_cnt  = 0;

    scard_activation_seq_if hif ();

    scard_activation_seq #(
        .DEBOUNCE_CYCLES(4),
        .T_PWR_CCLK     (8),
        .T_RST_CCLK     (16),
        .T_ATR_CCLK     (64),
        .T_DEACT_CLK    (4),
        .CNT_WIDTH      (16)
    ) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .cclk_tick_i    (cclk_tick),
        .card_inserted_i(card_inserted),
        .scard_io_i     (scard_io),
        .host           (hif.slave),
        .card_power_en_o(pwr),
        .card_oe_o      (oe),
        .card_clk_en_o  (clken),
        .card_rst_o     (crst),
        .card_present_o (present)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ins;
        logic        act;
        logic        tick;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [16];

    // {state, pwr, oe, clk_en, rst, present, ready, atr_seen, atr_timeout}
    function automatic logic [11:0] mk(input logic [2:0] st, input logic p, input logic o,
                                       input logic c, input logic r, input logic pr,
                                       input logic rd);
        return {st, p, o, c, r, pr, rd, 1'b0, 1'b0};
    endfunction

    function automatic logic [11:0] snap();
        return {hif.state_o, pwr, oe, clken, crst, present, hif.ready_o,
                hif.atr_seen_o, hif.atr_timeout_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input logic tk);
        cclk_tick = tk;
        @(posedge clk);
        #1;
        cclk_tick = 1'b0;
    endtask

    task automatic tick_pair();
        cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic pulse_act();
        hif.activate_i = 1'b1;
        cyc(1'b0);
        hif.activate_i = 1'b0;
    endtask

    task automatic wait_present();
        for (int i = 0; i < 20; i++) begin
            if (present) break;
            cyc(1'b0);
        end
        chk("present_up", present, 1);
    endtask

    // Called right after the DEACT entry edge; checks the 12-clk reverse ramp
    task automatic deact_seq(input logic p0, input logic o0, input logic c0);
        logic [6:0] e;
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b0);
            e = {(i < 12) ? 3'd6 : 3'd0, p0 & (i < 12), o0 & (i < 8), c0 & (i < 4), 1'b0};
            chk($sformatf("deact_t%0d", i), {hif.state_o, pwr, oe, clken, crst}, e);
        end
    endtask

    initial begin
        hif.activate_i   = 1'b0;
        hif.deactivate_i = 1'b0;

        // rst, ins, act, tick, expected
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 1, 0)};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, mk(3'd1, 1, 0, 0, 0, 1, 0)};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(3'd1, 1, 0, 0, 0, 1, 0)};

        for (int i = 0; i < 16; i++) begin
            reset_i        = tbl[i].rst;
            card_inserted  = tbl[i].ins;
            hif.activate_i = tbl[i].act;
            cyc(tbl[i].tick);
            hif.activate_i = 1'b0;
            chk($sformatf("vec%0d", i), snap(), tbl[i].exp);
        end

        // Normal activation: counters hold without ticks, then 8 + 16 ticks
        repeat (10) cyc(1'b0);
        chk("no_tick_hold", hif.state_o, 1);
        repeat (7) tick_pair();
        chk("pwr_wait", hif.state_o, 1);
        tick_pair();
        chk("clk_on", {hif.state_o, pwr, oe, clken, crst}, {3'd2, 4'b1110});
        repeat (15) tick_pair();
        chk("rst_wait", {hif.state_o, crst}, {3'd2, 1'b0});
        tick_pair();
        chk("wait_atr", {hif.state_o, pwr, oe, clken, crst}, {3'd3, 4'b1111});
        repeat (10) tick_pair();
        scard_io = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0);
            chk($sformatf("atr_seen_c%0d", k), hif.atr_seen_o, (k == 3) ? 1 : 0);
        end
        chk("active", {hif.state_o, hif.ready_o}, {3'd4, 1'b1});
        cyc(1'b0);
        chk("atr_single", hif.atr_seen_o, 0);
        scard_io = 1'b1;

        // ACTIVE: removal, deactivate and activate all on one clk
        card_inserted = 1'b0;
        repeat (5) cyc(1'b0);
        chk("pre_remove", {hif.state_o, present}, {3'd4, 1'b1});
        hif.deactivate_i = 1'b1;
        hif.activate_i   = 1'b1;
        cyc(1'b0);
        hif.deactivate_i = 1'b0;
        hif.activate_i   = 1'b0;
        chk("simul_deact", {hif.state_o, pwr, oe, clken, crst, present, hif.ready_o},
            {3'd6, 4'b1110, 1'b0, 1'b0});
        deact_seq(1'b1, 1'b1, 1'b1);

        // ATR timeout
        card_inserted = 1'b1;
        wait_present();
        pulse_act();
        chk("act2", hif.state_o, 1);
        repeat (24) tick_pair();
        chk("wait_atr2", hif.state_o, 3);
        repeat (63) tick_pair();
        chk("atr_t63", {hif.state_o, hif.atr_timeout_o}, {3'd3, 1'b0});
        tick_pair();
        chk("fault", {hif.state_o, hif.atr_timeout_o}, {3'd5, 1'b1});
        cyc(1'b0);
        chk("fault_deact", {hif.state_o, crst, hif.atr_timeout_o}, {3'd6, 1'b0, 1'b1});
        deact_seq(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b0);
        chk("timeout_sticky", {hif.state_o, hif.atr_timeout_o}, {3'd0, 1'b1});
        pulse_act();
        chk("timeout_clear", {hif.state_o, hif.atr_timeout_o}, {3'd1, 1'b0});

        // Removal mid-CLK_ON
        repeat (8) tick_pair();
        chk("clk_on3", hif.state_o, 2);
        card_inserted = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0);
            if (!present) break;
        end
        chk("removal_deact", {present, hif.state_o, crst}, {1'b0, 3'd6, 1'b0});
        deact_seq(1'b1, 1'b1, 1'b1);

        // io edge coincident with the final ATR tick: edge wins
        card_inserted = 1'b1;
        wait_present();
        pulse_act();
        repeat (24) tick_pair();
        chk("wait_atr4", hif.state_o, 3);
        repeat (63) tick_pair();
        scard_io = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        chk("edge_vs_tick", {hif.state_o, hif.atr_seen_o, hif.atr_timeout_o, hif.ready_o},
            {3'd4, 1'b1, 1'b0, 1'b1});
        scard_io = 1'b1;

        // Host deactivation from ACTIVE, then reset mid-POWER_UP
        hif.deactivate_i = 1'b1;
        cyc(1'b0);
        hif.deactivate_i = 1'b0;
        chk("host_deact", {hif.state_o, crst, hif.ready_o}, {3'd6, 1'b0, 1'b0});
        deact_seq(1'b1, 1'b1, 1'b1);
        pulse_act();
        chk("act5", hif.state_o, 1);
        tick_pair();
        tick_pair();
        reset_i = 1'b1;
        cyc(1'b0);
        reset_i = 1'b0;
        chk("mid_reset", snap(), 12'h000);
        repeat (5) cyc(1'b0);
        chk("requal_early", {present, hif.state_o}, {1'b0, 3'd0});
        cyc(1'b0);
        chk("requal", {present, hif.state_o, pwr}, {1'b1, 3'd0, 1'b0});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Backstop so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/scard_activation_seq.md
Name: scard_activation_seq

Overview:
- ISO7816-3 contact activation/deactivation sequencer for the smartcard slot.
- Sits between the slot pins (card_inserted, card_power_en, card_oe, card_clk gating, card_rst, card_io) and the serial smartcard engine / register block.
- Power-up, clock start, RST release and ATR detection are sequenced in hardware. Host issues activate/deactivate requests and reads status.

Parameters:
- DEBOUNCE_CYCLES, 16, clk cycles card_inserted must be stable before presence changes
- T_PWR_CCLK, 200, card-clock ticks of VCC before clock starts
- T_RST_CCLK, 400, card-clock ticks with clock running and RST low
- T_ATR_CCLK, 40000, card-clock ticks allowed after RST release for the ATR start bit
- T_DEACT_CLK, 16, clk cycles between deactivation steps
- CNT_WIDTH, 16, width of the shared timing counter (must hold T_ATR_CCLK)

Ports:
- clk  input  1  system clock, single domain
- reset_i  input  1  synchronous, active-high reset
- cclk_tick_i  input  1  one-clk pulse per card-clock period
- card_inserted_i  input  1  raw slot switch, asynchronous, high = card present
- scard_io_i  input  1  card I/O line level, asynchronous
- activate_i  input  1  one-clk activation request
- deactivate_i  input  1  one-clk deactivation request
- card_power_en_o  output  1  VCC enable
- card_oe_o  output  1  level-shifter/IO enable
- card_clk_en_o  output  1  gate for the card clock ODDR
- card_rst_o  output  1  card RST pin, 0 = reset asserted
- card_present_o  output  1  debounced presence
- ready_o  output  1  high in ACTIVE
- atr_seen_o  output  1  one-clk pulse on ATR start-bit detection
- atr_timeout_o  output  1  sticky ATR timeout flag
- state_o  output  3  current state encoding

Behaviour:
- Reset: all outputs 0, state OFF, counter 0, sync/debounce registers 0.
- Synchronisers: card_inserted_i and scard_io_i pass through 2-FF synchronisers. The io sync chain resets to 1.
- Debounce: card_present_o toggles only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive clk. Any bounce restarts the count.
- State encoding: OFF=0, POWER_UP=1, CLK_ON=2, WAIT_ATR=3, ACTIVE=4, FAULT=5, DEACT=6.
- Counter:
  - Cleared on every state entry.
  - Increments on cclk_tick_i in POWER_UP, CLK_ON and WAIT_ATR.
  - Increments every clk in DEACT.
- OFF:
  - Outputs all low.
  - activate_i with card_present_o=1: go to POWER_UP and clear atr_timeout_o.
  - activate_i with no card present: ignored.
- POWER_UP:
  - power_en=1.
  - When a tick arrives with counter==T_PWR_CCLK-1: go to CLK_ON.
- CLK_ON:
  - power_en=1, oe=1, clk_en=1, rst_o=0.
  - When a tick arrives with counter==T_RST_CCLK-1: go to WAIT_ATR.
- WAIT_ATR:
  - As CLK_ON but rst_o=1.
  - Synchronised io goes 1 to 0 (falling edge): pulse atr_seen_o and go to ACTIVE.
  - When a tick arrives with counter==T_ATR_CCLK-1: go to FAULT.
  - Edge and final tick in the same clk: edge wins.
- ACTIVE: ready_o=1, signals as WAIT_ATR. Held until a deactivation cause.
- FAULT: atr_timeout_o set. Next clk go to DEACT.
- DEACT:
  - Entry: rst_o=0 immediately.
  - After T_DEACT_CLK clk: clk_en=0.
  - After 2*T_DEACT_CLK: oe=0.
  - After 3*T_DEACT_CLK: power_en=0 and go to OFF.
  - Outputs already 0 stay 0.
  - Uses a 2-bit step index and restarts the counter per step.
- Deactivation causes, highest priority first:
  - card_present_o falling: applies in any state except OFF and DEACT, same clk.
  - deactivate_i: applies in POWER_UP, CLK_ON, WAIT_ATR and ACTIVE.
- Ignored requests:
  - activate_i outside OFF is ignored.
  - deactivate_i in OFF, FAULT or DEACT is ignored.
  - A new activation during DEACT is possible only after the return to OFF.
- reset_i mid-sequence: all outputs 0 on the next edge, regardless of state.
- No ticks: counters hold without cclk_tick_i. There is no clk-based timeout in tick-counted states.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, T_PWR_CCLK=8, T_RST_CCLK=16, T_ATR_CCLK=64, T_DEACT_CLK=4, tick every 2nd clk.
- Normal activation: insert card, wait for present. Pulse activate. Drive io low 10 ticks after RST rises.
  - power_en at +1 clk; clk_en/oe 8 ticks later; rst_o high 16 ticks later.
  - atr_seen_o single pulse 2-3 clk after the io edge (sync latency); ready_o=1, state_o=4.
- ATR timeout: io held high after RST release.
  - At tick 64: state 5 then 6; atr_timeout_o=1.
  - rst_o=0, then clk_en=0 +4 clk, oe=0 +8, power_en=0 +12, state 0.
  - atr_timeout_o stays 1 until the next accepted activate.
- Debounce: toggle card_inserted_i with 3-clk pulses -> card_present_o stays 0. Hold 4+ clk plus sync -> present=1. activate before that -> ignored, state 0.
- Removal mid-CLK_ON: drop card_inserted_i -> DEACT entered the clk present falls, full 12-clk reverse sequence, ends OFF.
- Simultaneous: in ACTIVE, the same clk carries deactivate_i, activate_i and a removal-induced present fall -> single DEACT entry, activate ignored. In WAIT_ATR, io edge coincident with tick 64 -> ACTIVE, atr_timeout_o=0.
- Reset mid-POWER_UP: assert reset_i 1 clk -> all outputs 0, state 0, card_present_o 0. Present re-qualifies after DEBOUNCE_CYCLES.
